// File: rtl/mips_load_store_unit.sv
// Load/store unit: byte-addressed requests -> word-addressed dmem, RMW for sub-word stores, big-endian lanes.
// Latency: load/word store done 2 cycles after accept, sub-word store 3; exc pulses 1 cycle after a rejected request.
// Backpressure: req_valid only sampled in IDLE (busy low); optional MIPS_LSU_RANGE_CHECK_EN rejects word index >= MEM_DEPTH.
module mips_load_store_unit #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              sig_mem_read,
    input  logic              sig_mem_write,
    input  logic [1:0]        mem_size,
    input  logic              sig_load_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic              busy,
    output logic              done,
    output logic [31:0]       load_data,
    output logic              exc,
    output logic [31:0]       dmem_address,
    output logic [31:0]       dmem_write_data,
    output logic              dmem_read,
    output logic              dmem_write,
    input  logic [31:0]       dmem_read_data
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, STORE, DONE} state_t;

    state_t state, state_nxt;

    logic [1:0]        size_q;
    logic              uns_q;
    logic [1:0]        off_q;
    logic [15:0]       sdat_q;
    logic [ADDR_W-1:0] word_idx;
    logic              illegal;
    logic              misaligned;
    logic              out_of_range;
    logic              reject;
    logic              accept;
    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;
    logic [31:0]       load_ext;
    logic [31:0]       merged;

    // Request decode, only meaningful while IDLE
    always_comb begin
        word_idx   = addr >> 2;
        illegal    = (sig_mem_read == sig_mem_write) || (mem_size == 2'b11);
        misaligned = ((mem_size == SZ_HALF) && addr[0]) ||
                     ((mem_size == SZ_WORD) && (addr[1:0] != 2'b00));
`ifdef MIPS_LSU_RANGE_CHECK_EN
        out_of_range = (64'(word_idx) >= 64'(MEM_DEPTH));
`else
        out_of_range = 1'b0;
`endif
        reject = illegal || misaligned || out_of_range;
        accept = (state == IDLE) && req_valid && !reject;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        dmem_read = 1'b0;
        dmem_write = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (sig_mem_read)            state_nxt = LOAD;
                    else if (mem_size == SZ_WORD) state_nxt = STORE;
                    else                          state_nxt = RMW_RD;
                end
            end
            LOAD: begin
                busy      = 1'b1;
                dmem_read = 1'b1;
                state_nxt = DONE;
            end
            RMW_RD: begin
                busy      = 1'b1;
                dmem_read = 1'b1;
                state_nxt = STORE;
            end
            STORE: begin
                busy       = 1'b1;
                dmem_write = 1'b1;
                state_nxt  = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Big-endian lane select: offset 0 is the most significant byte
    always_comb begin
        case (off_q)
            2'd0:    byte_lane = dmem_read_data[31:24];
            2'd1:    byte_lane = dmem_read_data[23:16];
            2'd2:    byte_lane = dmem_read_data[15:8];
            default: byte_lane = dmem_read_data[7:0];
        endcase
        half_lane = off_q[1] ? dmem_read_data[15:0] : dmem_read_data[31:16];

        case (size_q)
            SZ_BYTE: load_ext = uns_q ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            SZ_HALF: load_ext = uns_q ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
            default: load_ext = dmem_read_data;
        endcase

        merged = dmem_read_data;
        if (size_q == SZ_BYTE) begin
            case (off_q)
                2'd0:    merged[31:24] = sdat_q[7:0];
                2'd1:    merged[23:16] = sdat_q[7:0];
                2'd2:    merged[15:8]  = sdat_q[7:0];
                default: merged[7:0]   = sdat_q[7:0];
            endcase
        end else if (size_q == SZ_HALF) begin
            if (off_q[1]) merged[15:0]  = sdat_q;
            else          merged[31:16] = sdat_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size_q          <= 2'b00;
            uns_q           <= 1'b0;
            off_q           <= 2'b00;
            sdat_q          <= 16'h0;
            dmem_address    <= 32'h0;
            dmem_write_data <= 32'h0;
            load_data       <= 32'h0;
            exc             <= 1'b0;
        end else begin
            exc <= (state == IDLE) && req_valid && reject;
            if (accept) begin
                size_q       <= mem_size;
                uns_q        <= sig_load_unsigned;
                off_q        <= addr[1:0];
                sdat_q       <= store_data[15:0];
                dmem_address <= 32'(word_idx);
                // Word stores skip the read, so the write word is ready at accept
                if (sig_mem_write) dmem_write_data <= store_data;
            end
            if (state == LOAD)   load_data       <= load_ext;
            if (state == RMW_RD) dmem_write_data <= merged;
        end
    end

endmodule
